// File: rtl/reaction_pkg.sv
// Shared types, constants and BCD helpers for the reaction timer.
package reaction_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StGo,
      StDone,
      StEarly
   } state_t;

   // Four BCD digits, digit 3 is the most significant (thousands).
   typedef logic [3:0][3:0] bcd4_t;

   localparam bcd4_t BCD_MAX = 16'h9999;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Add one with decimal carry from digit 0 upward; 9999 wraps to 0000.
   function automatic bcd4_t bcd_inc(input bcd4_t v);
      bcd4_t r;
      logic  carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[i] == 4'd9) begin
               r[i] = 4'd0;
            end else begin
               r[i]  = r[i] + 4'd1;
               carry = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Strict a < b, decided by the first differing digit from the MSD.
   function automatic logic bcd_lt(input bcd4_t a, input bcd4_t b);
      logic lt;
      logic decided;
      lt      = 1'b0;
      decided = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (!decided && (a[i] != b[i])) begin
            lt      = (a[i] < b[i]);
            decided = 1'b1;
         end
      end
      return lt;
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick divider: one-cycle tick every DIV cycles, restartable via clr.
module ms_tick_gen #(
   parameter int unsigned DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] cnt_q;

   assign tick = (cnt_q == W'(DIV - 1));

   // Count 0..DIV-1; clr restarts so the first tick lands DIV cycles later.
   always_ff @(posedge clk) begin
      if (rst || clr || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: random fore-period, GO light, millisecond BCD reaction count,
// false-start and timeout detection.
// Optional build macro REACTION_BEST_EN adds the best_bcd output (best score).
module reaction_timer
   import reaction_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 100000000,
   parameter int unsigned MIN_WAIT_MS = 1000,
   parameter int unsigned RAND_BITS   = 11,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        btn,
   output logic        led_go,
   output logic        busy,
   output logic [15:0] result_bcd,
   output logic        result_valid,
   output logic        early,
`ifdef REACTION_BEST_EN
   output logic [15:0] best_bcd,
`endif
   output logic        timeout
);

   localparam int unsigned MS_DIV = CLK_HZ / 1000;

   state_t      state_q, state_d;
   logic [15:0] lfsr_q;
   logic [15:0] wait_q, wait_d;
   logic [15:0] wait_load;
   bcd4_t       cnt_q, cnt_d, cnt_inc;
   bcd4_t       result_q, result_d;
   logic        timeout_q, timeout_d;
   logic        valid_q, valid_d;
   logic        tick;
   logic        tick_clr;

   ms_tick_gen #(
      .DIV(MS_DIV)
   ) u_ms_tick_gen (
      .clk (clk),
      .rst (rst),
      .clr (tick_clr),
      .tick(tick)
   );

   assign wait_load = 16'(MIN_WAIT_MS) + 16'(lfsr_q[RAND_BITS-1:0]);
   assign cnt_inc   = bcd_inc(cnt_q);
   // Restart the millisecond phase on every state change.
   assign tick_clr  = (state_d != state_q);

   // Free-running LFSR; a non-zero seed keeps it out of the all-zero lock-up.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         wait_q    <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         timeout_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         timeout_q <= timeout_d;
         valid_q   <= valid_d;
      end
   end

   // Next-state logic and datapath updates.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      timeout_d = timeout_q;
      valid_d   = 1'b0;
      unique case (state_q)
         StIdle, StDone, StEarly: begin
            if (start) begin
               state_d   = StWait;
               wait_d    = wait_load;
               result_d  = '0;
               timeout_d = 1'b0;
            end
         end
         StWait: begin
            // A press anywhere in the fore-period is a false start, even on the expiry tick.
            if (btn) begin
               state_d = StEarly;
            end else if (tick) begin
               if (wait_q == 16'd1) begin
                  state_d = StGo;
                  cnt_d   = '0;
               end else begin
                  wait_d = wait_q - 16'd1;
               end
            end
         end
         StGo: begin
            if (btn) begin
               state_d  = StDone;
               result_d = cnt_q;
               valid_d  = 1'b1;
            end else if (tick) begin
               if (cnt_inc == BCD_MAX) begin
                  state_d   = StDone;
                  cnt_d     = BCD_MAX;
                  result_d  = BCD_MAX;
                  timeout_d = 1'b1;
                  valid_d   = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef REACTION_BEST_EN
   bcd4_t best_q;

   // Track the fastest non-timeout result; visible the cycle after result_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         best_q <= BCD_MAX;
      end else if (valid_q && !timeout_q && bcd_lt(result_q, best_q)) begin
         best_q <= result_q;
      end
   end

   assign best_bcd = best_q;
`endif

   assign led_go       = (state_q == StGo);
   assign busy         = (state_q == StWait) || (state_q == StGo);
   assign early        = (state_q == StEarly);
   assign result_bcd   = result_q;
   assign result_valid = valid_q;
   assign timeout      = timeout_q;

endmodule
